// File: rtl/aer_sync_encoder.sv
`timescale 1ns/1ps
// aer_sync_encoder
// Row/column address-event encoder for a ROWS x COLS ON/OFF pixel array.
// Rising edges on the spike lines set per-pixel pending bits. One pending
// event at a time is arbitrated, using either fixed priority or round-robin.
// The winner is sent off-chip with a 4-phase req/ack handshake.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   spk_on/spk_off   ON/OFF spike lines, pixel index i = y*COLS + x
//   greedy           1 = lowest index wins, 0 = round-robin
//   aer_dis          masks capture and blocks new arbitration
//   ack              asynchronous 4-phase acknowledge from the receiver
//   req_on/req_off   event request, at most one high at a time
//   addr_x/addr_y    column/row address of the event in flight
//   busy             handshake FSM not in IDLE
//   drop_cnt         saturating count of lost events
//   ack_to_err       sticky ack-timeout flag
//
// Optional feature: define AER_ACK_TIMEOUT_EN to add an ack timeout of
// TIMEOUT_CYC cycles in REQ/ACKLO. Without it ack_to_err is constant 0.
//
// Handshake: req_on/req_off rises only after the address has been stable
// for at least one cycle. req stays high until the synchronised ack is seen
// high. The FSM then waits for ack to return low before it arbitrates again.
//
// Round-robin note: the row pointer stays on the granted row while that row
// still has pending pixels. A row is therefore drained column by column
// before the search moves on to the next pending row. Both pointers hold the
// index where the next search starts. Their reset value of 0 means the
// search begins at row 0, column 0.
module aer_sync_encoder #(
    parameter int ROWS        = 12,
    parameter int COLS        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1023,
    localparam int AXW        = $clog2(COLS),
    localparam int AYW        = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS*COLS-1:0] spk_on,
    input  logic [ROWS*COLS-1:0] spk_off,
    input  logic                 greedy,
    input  logic                 aer_dis,
    input  logic                 ack,
    output logic                 req_on,
    output logic                 req_off,
    output logic [AXW-1:0]       addr_x,
    output logic [AYW-1:0]       addr_y,
    output logic                 busy,
    output logic [15:0]          drop_cnt,
    output logic                 ack_to_err
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);

    if (ROWS < 2 || COLS < 2 || SYNC_STAGES < 1 || SYNC_STAGES > 3 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("aer_sync_encoder: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, SETUP, REQ, ACKLO} state_t;
    state_t state;

    logic [N-1:0] on_d, on_q, off_d, off_q;
    logic [N-1:0] pend_on, pend_off, pend_any;
    logic [N-1:0] cap_on, cap_off, clr_on, clr_off;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic ack_s;
    logic pol_q;
    logic [AYW-1:0] row_ptr, sel_row, row_lo, row_hi;
    logic [AXW-1:0] col_ptr, sel_col, col_lo, col_hi;
    logic row_hi_ok, col_hi_ok;
    logic [ROWS-1:0] row_cand;
    logic [COLS-1:0] col_cand;
    logic [IW-1:0] sel_idx, srv_idx;
    logic sel_on, sel_off, row_rest, any_pend;
    logic served, drop_evt, tmo_hit, tmo_req, tmo_ack;
    int row_start, col_start;

    // ---------------- ack synchroniser ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync[0] <= ack;
            for (int i = 1; i < SYNC_STAGES; i++) ack_sync[i] <= ack_sync[i-1];
        end
    end
    assign ack_s = ack_sync[SYNC_STAGES-1];

    // ---------------- capture ----------------
    // The spike lines are registered once (on_d) and then delayed again
    // (on_q). An edge is a 0->1 step between these two registers.
    assign cap_on   = on_d  & ~on_q  & {N{~aer_dis}};
    assign cap_off  = off_d & ~off_q & {N{~aer_dis}};
    assign pend_any = pend_on | pend_off;
    assign any_pend = |pend_any;

    // The served pixel is cleared when ack arrives or on a timeout in REQ.
    assign served  = (state == REQ) && (ack_s || tmo_hit);
    assign srv_idx = IW'(addr_y) * IW'(COLS) + IW'(addr_x);

    always_comb begin
        clr_on  = '0;
        clr_off = '0;
        for (int i = 0; i < N; i++) begin
            if (served && srv_idx == IW'(i)) begin
                clr_on[i]  = pol_q;
                clr_off[i] = ~pol_q;
            end
        end
    end

    // A re-edge on a bit that stays pending is a lost event. Several losses
    // in one cycle count once.
    assign drop_evt = (|(cap_on & pend_on & ~clr_on)) | (|(cap_off & pend_off & ~clr_off)) | tmo_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            on_d     <= '0;
            on_q     <= '0;
            off_d    <= '0;
            off_q    <= '0;
            pend_on  <= '0;
            pend_off <= '0;
            drop_cnt <= '0;
        end else begin
            on_d     <= spk_on;
            on_q     <= on_d;
            off_d    <= spk_off;
            off_q    <= off_d;
            // Set wins over clear when both hit the same bit.
            pend_on  <= (pend_on  & ~clr_on)  | cap_on;
            pend_off <= (pend_off & ~clr_off) | cap_off;
            if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // ---------------- arbitration ----------------
    // Descending scans: the last hit is the lowest index. The "hi" result
    // only takes candidates at or above the start pointer. If none exist
    // there, the search wraps to the lowest candidate overall.
    always_comb begin
        row_start = greedy ? 0 : int'(row_ptr);
        row_lo    = '0;
        row_hi    = '0;
        row_hi_ok = 1'b0;
        for (int r = 0; r < ROWS; r++) row_cand[r] = |pend_any[r*COLS +: COLS];
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_cand[r]) begin
                row_lo = AYW'(r);
                if (r >= row_start) begin
                    row_hi    = AYW'(r);
                    row_hi_ok = 1'b1;
                end
            end
        end
        sel_row = row_hi_ok ? row_hi : row_lo;

        col_cand  = pend_any[IW'(sel_row) * IW'(COLS) +: COLS];
        col_start = greedy ? 0 : int'(col_ptr);
        col_lo    = '0;
        col_hi    = '0;
        col_hi_ok = 1'b0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_cand[c]) begin
                col_lo = AXW'(c);
                if (c >= col_start) begin
                    col_hi    = AXW'(c);
                    col_hi_ok = 1'b1;
                end
            end
        end
        sel_col = col_hi_ok ? col_hi : col_lo;

        sel_idx = IW'(sel_row) * IW'(COLS) + IW'(sel_col);
        sel_on  = pend_on[sel_idx];
        sel_off = pend_off[sel_idx];

        // Row still has work after this grant: another column is pending, or
        // this pixel also has its OFF event waiting behind the ON one.
        row_rest = sel_on & sel_off;
        for (int c = 0; c < COLS; c++) begin
            if (col_cand[c] && AXW'(c) != sel_col) row_rest = 1'b1;
        end
    end

    // ---------------- ack timeout (optional) ----------------
`ifdef AER_ACK_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYC >= 1024) ? $clog2(TIMEOUT_CYC + 1) : 10;
    logic [TCW-1:0] tcnt;
    logic in_wait, leave;

    assign in_wait = (state == REQ) || (state == ACKLO);
    assign tmo_hit = in_wait && (tcnt == TCW'(TIMEOUT_CYC - 1));
    assign leave   = ((state == REQ) && (ack_s || tmo_hit)) || ((state == ACKLO) && (!ack_s || tmo_hit));

    // The counter restarts on every state change. tcnt == k during the
    // (k+1)-th cycle spent in the state.
    always_ff @(posedge clk) begin
        if (rst || !in_wait || leave) tcnt <= '0;
        else                          tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                      ack_to_err <= 1'b0;
        else if (tmo_req || tmo_ack)  ack_to_err <= 1'b1;
    end
`else
    assign tmo_hit    = 1'b0;
    assign ack_to_err = 1'b0;
`endif

    assign tmo_req = (state == REQ)   && !ack_s && tmo_hit;
    assign tmo_ack = (state == ACKLO) &&  ack_s && tmo_hit;

    // ---------------- handshake FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_on  <= 1'b0;
            req_off <= 1'b0;
            addr_x  <= '0;
            addr_y  <= '0;
            pol_q   <= 1'b0;
            busy    <= 1'b0;
            row_ptr <= '0;
            col_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend && !aer_dis && !ack_s) begin
                        addr_x  <= sel_col;
                        addr_y  <= sel_row;
                        pol_q   <= sel_on;
                        row_ptr <= row_rest ? sel_row : ((sel_row == AYW'(ROWS - 1)) ? '0 : sel_row + 1'b1);
                        col_ptr <= (sel_col == AXW'(COLS - 1)) ? '0 : sel_col + 1'b1;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    req_on  <= pol_q;
                    req_off <= ~pol_q;
                    state   <= REQ;
                end
                REQ: begin
                    if (ack_s) begin
                        req_on  <= 1'b0;
                        req_off <= 1'b0;
                        state   <= ACKLO;
                    end else if (tmo_req) begin
                        req_on  <= 1'b0;
                        req_off <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ACKLO: begin
                    if (!ack_s || tmo_ack) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aer_sync_encoder.sv
`timescale 1ns/1ps
// tb_aer_sync_encoder
// Self-checking bench for aer_sync_encoder. The main thread pushes each
// expected event {pol_on, y, x} onto exp_q when it drives the spikes. A
// negedge monitor pops and compares the queue on every req rising edge.
// A background responder returns ack when auto_ack is set. Otherwise the
// main thread drives ack by hand.
module tb_aer_sync_encoder;

    localparam int ROWS = 12;
    localparam int COLS = 16;
    localparam int N    = ROWS * COLS;
`ifdef AER_ACK_TIMEOUT_EN
    localparam int TMO  = 20;
`else
    localparam int TMO  = 1023;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] spk_on = '0;
    logic [N-1:0] spk_off = '0;
    logic         greedy = 1'b0;
    logic         aer_dis = 1'b0;
    logic         ack;
    logic         ack_auto = 1'b0;
    logic         ack_man = 1'b0;
    logic         auto_ack = 1'b0;
    logic         req_on, req_off, busy, ack_to_err;
    logic [3:0]   addr_x, addr_y;
    logic [15:0]  drop_cnt;

    logic [8:0]   exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           hs_cnt = 0;

    assign ack = auto_ack ? ack_auto : ack_man;

    aer_sync_encoder #(
        .ROWS(ROWS), .COLS(COLS), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .spk_on(spk_on), .spk_off(spk_off),
        .greedy(greedy), .aer_dis(aer_dis), .ack(ack),
        .req_on(req_on), .req_off(req_off), .addr_x(addr_x), .addr_y(addr_y),
        .busy(busy), .drop_cnt(drop_cnt), .ack_to_err(ack_to_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ack responder ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && (req_on || req_off) && !ack_auto) begin
                repeat (2) @(negedge clk);
                ack_auto = 1'b1;
            end else if (ack_auto && !(req_on || req_off)) begin
                repeat (2) @(negedge clk);
                ack_auto = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic       prev_req = 1'b0;
    logic [8:0] cur = '0;
    logic [8:0] exp_v;

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (req_on && req_off) begin
                bad++;
                $display("FAIL req_onehot: req_on=%b req_off=%b, need at most one", req_on, req_off);
            end
            if ((req_on || req_off) && !prev_req) begin
                cur = {req_on, addr_y, addr_x};
                hs_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_req: got pol=%b y=%0d x=%0d, none expected", cur[8], cur[7:4], cur[3:0]);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (cur !== exp_v) begin
                        bad++;
                        $display("FAIL event_order: got pol=%b y=%0d x=%0d, need pol=%b y=%0d x=%0d",
                                 cur[8], cur[7:4], cur[3:0], exp_v[8], exp_v[7:4], exp_v[3:0]);
                    end
                end
            end else if ((req_on || req_off) && prev_req) begin
                total++;
                if ({req_on, addr_y, addr_x} !== cur) begin
                    bad++;
                    $display("FAIL addr_stable: got %h, need %h while req high", {req_on, addr_y, addr_x}, cur);
                end
            end
        end
        prev_req = req_on || req_off;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, need %0h", name, got, want);
        end
    endtask

    task automatic do_reset(input bit g);
        @(negedge clk);
        rst      = 1'b1;
        greedy   = g;
        aer_dis  = 1'b0;
        auto_ack = 1'b0;
        ack_man  = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                for (int i = 0; i < N; i++) begin
                    spk_on[i]  = 1'($urandom_range(0, 1));
                    spk_off[i] = 1'($urandom_range(0, 1));
                end
            end else begin
                spk_on  = '0;
                spk_off = '0;
            end
            @(posedge clk);
            #1;
            check("reset_outputs", {4'h0, req_on, req_off, addr_x, addr_y, busy, drop_cnt, ack_to_err}, 32'h0);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, (exp_q.size() == 0 && !busy)}, 32'h1);
    endtask

    task automatic hs_wait_req(input string name);
        int n = 0;
        while (!(req_on || req_off) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, (req_on || req_off)}, 32'h1);
    endtask

    task automatic hs_finish(input string name, input bit respike0);
        int n = 0;
        ack_man = 1'b1;
        while ((req_on || req_off) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, (req_on || req_off)}, 32'h0);
        if (respike0) begin
            spk_on[0] = 1'b1;
            @(negedge clk);
            spk_on[0] = 1'b0;
        end
        repeat (3) @(negedge clk);
        ack_man = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int pix;
        bit on;
        int ey;
        int ex;
    } vec_t;

    vec_t tbl[7];
    int   hs0;
    int   n_hi;

    initial begin
        tbl[0] = '{66,  1'b1, 4,  2};
        tbl[1] = '{0,   1'b0, 0,  0};
        tbl[2] = '{191, 1'b1, 11, 15};
        tbl[3] = '{15,  1'b0, 0,  15};
        tbl[4] = '{16,  1'b1, 1,  0};
        tbl[5] = '{100, 1'b0, 6,  4};
        tbl[6] = '{130, 1'b1, 8,  2};

        // Single events: latency and address, one table entry at a time.
        do_reset(1'b0);
        auto_ack = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exp_q.push_back({tbl[i].on, 4'(tbl[i].ey), 4'(tbl[i].ex)});
            if (tbl[i].on) spk_on[tbl[i].pix]  = 1'b1;
            else           spk_off[tbl[i].pix] = 1'b1;
            @(posedge clk);                 // edge k samples the spike
            @(negedge clk);
            spk_on  = '0;
            spk_off = '0;
            @(posedge clk);                 // k+1: pending set
            @(posedge clk);                 // k+2: SETUP
            #1;
            check("latency_k2_no_req", {30'b0, req_on, req_off}, 32'h0);
            @(posedge clk);                 // k+3: req high
            #1;
            check("latency_k3_req", {30'b0, req_on, req_off}, tbl[i].on ? 32'h2 : 32'h1);
            wait_drain("single_drain", 100);
        end
        check("single_drop_cnt", {16'b0, drop_cnt}, 32'h0);

        // Round-robin: all ON spikes at once, row-major order expected.
        do_reset(1'b0);
        auto_ack = 1'b1;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                exp_q.push_back({1'b1, 4'(y), 4'(x)});
        hs0 = hs_cnt;
        @(negedge clk);
        spk_on = '1;
        @(negedge clk);
        spk_on = '0;
        wait_drain("rr_drain", 8000);
        check("rr_handshakes", hs_cnt - hs0, 32'd192);
        check("rr_drop_cnt", {16'b0, drop_cnt}, 32'h0);

        // Fixed priority: pixel 0 keeps winning while it is re-spiked.
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) exp_q.push_back(9'h100);
        exp_q.push_back(9'h1BF);
        @(negedge clk);
        spk_on[0]   = 1'b1;
        spk_on[191] = 1'b1;
        @(negedge clk);
        spk_on = '0;
        for (int i = 0; i < 5; i++) begin
            hs_wait_req("greedy_req");
            hs_finish("greedy_req_fall", i < 4);
        end
        hs_wait_req("greedy_req_191");
        hs_finish("greedy_req_fall_191", 1'b0);
        wait_drain("greedy_drain", 100);
        check("greedy_drop_cnt", {16'b0, drop_cnt}, 32'h0);

        // Both polarities on pixel 69, plus a re-edge while ON is pending.
        do_reset(1'b0);
        auto_ack = 1'b1;
        exp_q.push_back(9'h145);
        exp_q.push_back(9'h045);
        @(negedge clk);
        spk_on[69]  = 1'b1;
        spk_off[69] = 1'b1;
        @(negedge clk);
        spk_on  = '0;
        spk_off = '0;
        @(negedge clk);
        spk_on[69] = 1'b1;
        @(negedge clk);
        spk_on = '0;
        wait_drain("both_pol_drain", 200);
        check("both_pol_drop_cnt", {16'b0, drop_cnt}, 32'h1);

        // aer_dis mid-handshake: pixel 10 completes, 49/181 are masked,
        // pending pixel 59 waits until aer_dis is released.
        do_reset(1'b0);
        exp_q.push_back(9'h10A);
        exp_q.push_back(9'h13B);
        hs0 = hs_cnt;
        @(negedge clk);
        spk_on[10] = 1'b1;
        spk_on[59] = 1'b1;
        @(negedge clk);
        spk_on = '0;
        hs_wait_req("dis_req_10");
        aer_dis     = 1'b1;
        spk_on[49]  = 1'b1;
        spk_off[181] = 1'b1;
        @(negedge clk);
        spk_on  = '0;
        spk_off = '0;
        hs_finish("dis_req_fall_10", 1'b0);
        repeat (40) @(negedge clk);
        check("dis_59_waiting", exp_q.size(), 32'd1);
        check("dis_idle", {31'b0, busy}, 32'h0);
        aer_dis = 1'b0;
        hs_wait_req("dis_req_59");
        hs_finish("dis_req_fall_59", 1'b0);
        repeat (40) @(negedge clk);
        check("dis_queue_empty", exp_q.size(), 32'd0);
        check("dis_handshakes", hs_cnt - hs0, 32'd2);
        check("dis_drop_cnt", {16'b0, drop_cnt}, 32'h0);

`ifdef AER_ACK_TIMEOUT_EN
        // Ack timeout: ack held low, req must drop after TMO cycles in REQ.
        do_reset(1'b0);
        exp_q.push_back(9'h103);
        exp_q.push_back(9'h114);
        @(negedge clk);
        spk_on[3]  = 1'b1;
        spk_on[20] = 1'b1;
        @(negedge clk);
        spk_on = '0;
        hs_wait_req("tmo_req_3");
        n_hi = 0;
        while ((req_on || req_off) && n_hi < 100) begin
            n_hi++;
            @(negedge clk);
        end
        check("tmo_req_cycles", n_hi, TMO);
        check("tmo_err_flag", {31'b0, ack_to_err}, 32'h1);
        check("tmo_drop_cnt", {16'b0, drop_cnt}, 32'h1);
        hs_wait_req("tmo_next_req_20");
        hs_finish("tmo_next_fall_20", 1'b0);
        wait_drain("tmo_drain", 100);
        check("tmo_err_sticky", {31'b0, ack_to_err}, 32'h1);
        check("tmo_drop_after", {16'b0, drop_cnt}, 32'h1);
`else
        check("no_tmo_err_flag", {31'b0, ack_to_err}, 32'h0);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
